// File: rtl/nib_loader_pkg.sv
// Shared types and helpers for the NIB whole-track loader.
package nib_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        LOAD
    } state_t;

    localparam int SECTOR_BYTES = 512;

    // First SD sector of a track: track number times sectors per track.
    function automatic logic [63:0] lba_of(input logic [63:0] trk, input int secs);
        return trk * 64'(secs);
    endfunction

endpackage

// File: rtl/sd_sector_seq.sv
// Sector handshake sequencer: drives one hps_io request level, walks sd_lba and
// buf_sec across the sectors of a track, and reports sector and phase completion.
module sd_sector_seq #(
    parameter int DRIVES         = 2,
    parameter int DRV_W          = 1,
    parameter int SECS_PER_TRACK = 13,
    parameter int SEC_W          = 4,
    parameter int LBA_W          = 32
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic              start_wr,
    input  logic [DRV_W-1:0]  start_drv,
    input  logic [LBA_W-1:0]  start_lba,
    input  logic [DRIVES-1:0] sd_ack,
    output logic [LBA_W-1:0]  sd_lba,
    output logic [DRIVES-1:0] sd_rd,
    output logic [DRIVES-1:0] sd_wr,
    output logic [SEC_W-1:0]  buf_sec,
    output logic              sec_done,
    output logic              phase_done
);

    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(SECS_PER_TRACK - 1);

    logic              req;
    logic              wr;
    logic              active;
    logic [DRV_W-1:0]  drv;
    logic [DRIVES-1:0] ack_q;
    logic              ack_rise;
    logic              ack_fall;

    assign ack_rise   = active &&  sd_ack[drv] && !ack_q[drv];
    assign ack_fall   = active && !sd_ack[drv] &&  ack_q[drv];
    assign sec_done   = ack_fall;
    // The request was dropped on the last sector's rising ack, so a falling
    // ack with the request already low closes the phase.
    assign phase_done = ack_fall && !req;

    // Decode the request level onto the selected drive's rd or wr line.
    always_comb begin
        sd_rd = '0;
        sd_wr = '0;
        if (req) begin
            if (wr) sd_wr[drv] = 1'b1;
            else    sd_rd[drv] = 1'b1;
        end
    end

    // Request level, ack history and the lba/sector counters.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            req     <= 1'b0;
            wr      <= 1'b0;
            active  <= 1'b0;
            drv     <= '0;
            ack_q   <= '0;
            sd_lba  <= '0;
            buf_sec <= '0;
        end else begin
            ack_q <= sd_ack;
            if (start) begin
                req     <= 1'b1;
                wr      <= start_wr;
                active  <= 1'b1;
                drv     <= start_drv;
                sd_lba  <= start_lba;
                buf_sec <= '0;
            end else begin
                if (ack_rise) begin
                    sd_lba <= sd_lba + LBA_W'(1);
                    if (buf_sec == LAST_SEC) req <= 1'b0;
                end
                if (ack_fall) begin
                    buf_sec <= buf_sec + SEC_W'(1);
                    if (!req) active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/nib_track_loader.sv
// Whole-track loader / write-back engine between hps_io and the NIB track buffers.
//
// state | meaning
// IDLE  | arbitrating among pending drives
// FLUSH | writing the dirty cur_track of sel back to the image
// LOAD  | reading the requested track of sel into the buffer
module nib_track_loader
    import nib_loader_pkg::*;
#(
    parameter int DRIVES         = 2,
    parameter int SECS_PER_TRACK = 13,
    parameter int TRACK_W        = 6,
    parameter int LBA_W          = 32,
    parameter int WAIT_FULL      = 0,
    localparam int DRV_W         = (DRIVES > 1) ? $clog2(DRIVES) : 1,
    localparam int SEC_W         = $clog2(SECS_PER_TRACK)
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [DRIVES*TRACK_W-1:0] track,
    input  logic [DRIVES-1:0]         dirty_set,
    input  logic [DRIVES-1:0]         img_mounted,
    input  logic [DRIVES-1:0]         img_present,
    output logic [LBA_W-1:0]          sd_lba,
    output logic [DRIVES-1:0]         sd_rd,
    output logic [DRIVES-1:0]         sd_wr,
    input  logic [DRIVES-1:0]         sd_ack,
    output logic [DRV_W-1:0]          buf_drive,
    output logic [SEC_W-1:0]          buf_sec,
    output logic                      cpu_wait,
    output logic [DRIVES-1:0]         drive_ready,
    output logic                      busy
);

    state_t             state;
    logic [DRV_W-1:0]   sel;
    logic [TRACK_W-1:0] cur_track [DRIVES];
    logic [TRACK_W-1:0] trk_in    [DRIVES];
    logic [DRIVES-1:0]  loaded;
    logic [DRIVES-1:0]  dirty;
    logic [DRIVES-1:0]  remount;
    logic [DRIVES-1:0]  pend;
    logic [DRV_W-1:0]   pick;
    logic               flush_go;
    logic               load_go;
    logic [DRV_W-1:0]   start_drv;
    logic [LBA_W-1:0]   start_lba;
    logic               sec_done;
    logic               phase_done;

    assign buf_drive = sel;
    assign busy      = (state != IDLE);

    // Per-drive requested track, pending flags and lowest-index winner.
    always_comb begin
        pend = '0;
        pick = '0;
        for (int d = DRIVES - 1; d >= 0; d--) begin
            trk_in[d]      = track[d*TRACK_W +: TRACK_W];
            pend[d]        = img_present[d] &&
                             (!loaded[d] || trk_in[d] != cur_track[d] || remount[d]);
            drive_ready[d] = loaded[d] && trk_in[d] == cur_track[d];
            if (pend[d]) pick = DRV_W'(d);
        end
    end

    // Phase starts: arbitration out of IDLE, or the load that follows a flush.
    // A mount arriving in the arbitration cycle means the old image is gone,
    // so the write-back is skipped.
    always_comb begin
        flush_go  = 1'b0;
        load_go   = 1'b0;
        start_drv = sel;
        start_lba = '0;
        if (state == IDLE && pend != '0) begin
            start_drv = pick;
            if (dirty[pick] && loaded[pick] && !remount[pick] && !img_mounted[pick]) begin
                flush_go  = 1'b1;
                start_lba = LBA_W'(lba_of(64'(cur_track[pick]), SECS_PER_TRACK));
            end else begin
                load_go   = 1'b1;
                start_lba = LBA_W'(lba_of(64'(trk_in[pick]), SECS_PER_TRACK));
            end
        end else if (state == FLUSH && phase_done) begin
            load_go   = 1'b1;
            start_lba = LBA_W'(lba_of(64'(trk_in[sel]), SECS_PER_TRACK));
        end
    end

    sd_sector_seq #(
        .DRIVES         (DRIVES),
        .DRV_W          (DRV_W),
        .SECS_PER_TRACK (SECS_PER_TRACK),
        .SEC_W          (SEC_W),
        .LBA_W          (LBA_W)
    ) u_seq (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .start      (flush_go || load_go),
        .start_wr   (flush_go),
        .start_drv  (start_drv),
        .start_lba  (start_lba),
        .sd_ack     (sd_ack),
        .sd_lba     (sd_lba),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .buf_sec    (buf_sec),
        .sec_done   (sec_done),
        .phase_done (phase_done)
    );

    // Per-drive bookkeeping; later assignments take priority (dirty_set beats
    // the clear at phase start, a missing image always clears loaded).
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            loaded  <= '0;
            dirty   <= '0;
            remount <= '0;
            for (int d = 0; d < DRIVES; d++) cur_track[d] <= '1;
        end else begin
            for (int d = 0; d < DRIVES; d++) begin
                if ((flush_go || load_go) && start_drv == DRV_W'(d)) dirty[d] <= 1'b0;
                if (dirty_set[d]) dirty[d] <= 1'b1;
                if (img_mounted[d]) remount[d] <= 1'b1;
                if (load_go && start_drv == DRV_W'(d)) begin
                    remount[d]   <= 1'b0;
                    loaded[d]    <= 1'b0;
                    cur_track[d] <= trk_in[d];
                end
                if (state == LOAD && phase_done && sel == DRV_W'(d)) loaded[d] <= 1'b1;
                if (!img_present[d]) loaded[d] <= 1'b0;
            end
        end
    end

    // Main FSM with registered drive select and CPU stall.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sel      <= '0;
            cpu_wait <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_go) begin
                        state    <= FLUSH;
                        sel      <= pick;
                        cpu_wait <= 1'b1;
                    end else if (load_go) begin
                        state    <= LOAD;
                        sel      <= pick;
                        cpu_wait <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (phase_done) state <= LOAD;
                end
                LOAD: begin
                    if (sec_done && WAIT_FULL == 0) cpu_wait <= 1'b0;
                    if (phase_done) begin
                        state    <= IDLE;
                        cpu_wait <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/nib_track_loader.md
# nib_track_loader

Parametrised whole-track loader and write-back engine between the hps_io SD sector interface and the per-drive NIB track buffers of the Apple II disk controller. It watches each drive's requested track and loads that track's sectors into the track RAM. It writes a modified track back to the image before replacing it. It stalls the CPU through `cpu_wait` while the data it needs is not yet present.

## Interface
- `DRIVES`, default 2: number of drives, 1..4; `DRV_W = max(1, $clog2(DRIVES))`.
- `SECS_PER_TRACK`, default 13: 512-byte SD sectors per track; `SEC_W = $clog2(SECS_PER_TRACK)`.
- `TRACK_W`, default 6: track number width.
- `LBA_W`, default 32: SD LBA width.
- `WAIT_FULL`, default 0: 1 holds `cpu_wait` for the whole operation; 0 releases it after the first loaded sector completes.
- `clk_sys` in 1: system clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `track` in DRIVES×TRACK_W: requested track per drive.
- `dirty_set` in DRIVES: one-cycle pulse; the controller wrote that drive's track buffer.
- `img_mounted` in DRIVES: one-cycle pulse; a new image was mounted.
- `img_present` in DRIVES: 1 when the image size is non-zero.
- `sd_lba` out LBA_W: sector address to hps_io.
- `sd_rd`, `sd_wr` out DRIVES: per-drive level requests.
- `sd_ack` in DRIVES: hps_io acknowledge, high during a sector transfer.
- `buf_drive` out DRV_W: drive whose buffer is being accessed.
- `buf_sec` out SEC_W: sector index within the track; forms the buffer address `{buf_sec, sd_buff_addr}`.
- `cpu_wait` out 1: CPU stall.
- `drive_ready` out DRIVES: buffer holds a valid copy of `cur_track[d]`.
- `busy` out 1: state is not IDLE.

## Operation
- Per-drive registers: `cur_track[d]`, `loaded[d]`, `dirty[d]`, `remount[d]`.
- `dirty[d]` is set by `dirty_set[d]` and cleared when FLUSH starts for drive d.
- `remount[d]` is set by `img_mounted[d]`.
- A drive is pending when `img_present[d]` and any of these holds: `!loaded[d]`, `track[d] != cur_track[d]`, or `remount[d]`.
- In IDLE, the lowest-index pending drive wins and is latched as `sel`.
- Flush decision for `sel`:
  - If `dirty[sel]`, `loaded[sel]` and `!remount[sel]`, go to FLUSH with `sd_wr[sel]` and the LBA of `cur_track[sel]`.
  - Otherwise go directly to LOAD.
- LOAD entry:
  - Latch `cur_track[sel] <= track[sel]`.
  - Clear `remount[sel]`, `dirty[sel]` and `loaded[sel]`.
  - Assert `sd_rd[sel]`.
  - `sd_lba = cur_track*SECS_PER_TRACK`, computed at LBA_W width with zero extension.
  - `buf_sec = 0`.
- Sector handshake, shared by FLUSH and LOAD:
  - On the `sd_ack[sel]` rising edge: `sd_lba += 1`. If `buf_sec == SECS_PER_TRACK-1`, drop the request.
  - On the `sd_ack[sel]` falling edge: `buf_sec += 1`.
  - If the request is already low at that falling edge, the phase ends. FLUSH → LOAD; LOAD → IDLE with `loaded[sel] = 1`.
- If `track[sel]` changes during LOAD, the load completes and the drive is pending again in the next IDLE cycle.
- If `img_mounted[sel]` arrives mid-phase, it only sets `remount`. The running sector handshake always completes, because hps_io cannot abort a transfer.
- If a drive has `img_present = 0`, it is never pending and its `loaded` is cleared.
- `drive_ready[d] = loaded[d] && track[d] == cur_track[d]`.
- `cpu_wait`:
  - Set on IDLE→LOAD/FLUSH.
  - With `WAIT_FULL = 0`, cleared at the first LOAD sector falling edge.
  - With `WAIT_FULL = 1`, cleared on the return to IDLE.

## Timing
- Reset values:
  - `sd_rd`, `sd_wr`, `cpu_wait`, `busy`, `drive_ready` = 0.
  - `sd_lba = 0`, `buf_sec = 0`, `buf_drive = 0`.
  - All `loaded`, `dirty`, `remount` = 0; `cur_track` = all-ones.
- Async reset mid-operation drops every request in the same instant. The next load restarts from sector 0.
- Arbitration: one cycle in IDLE. The request is asserted on the cycle after the decision.
- Edges are detected from a one-cycle registered `sd_ack`. `sd_lba` and `buf_sec` update the cycle after the detected edge.
- `buf_sec` wraps never: the maximum value is `SECS_PER_TRACK-1` during the last transfer. It reads `SECS_PER_TRACK` only in the final cycle of the phase and is reset on the next phase.
- `dirty_set` coinciding with FLUSH start leaves `dirty` set.
- `img_mounted` coinciding with arbitration suppresses the flush.

## Structure
- Package `nib_loader_pkg`:
  - State enum {IDLE, FLUSH, LOAD}.
  - Sector size 512.
  - `lba_of(track)` helper function.
- Sub-module `sd_sector_seq`:
  - Owns request level, ack edge detection, the `sd_lba`/`buf_sec` counters and the last-sector logic.
  - Top level holds arbitration and per-drive state.

## Test plan
- Mount drive 0 (`img_present = 1`), `track = 0` → 13 `sd_rd` transfers, LBAs 0..12, `buf_sec` 0..12, then `drive_ready[0] = 1`.
- Step drive 0 to track 5 with `WAIT_FULL = 0` → LBAs 65..77. `cpu_wait` falls after sector 0's ack falling edge.
- `dirty_set[0]` on track 5, then step to 6 → `sd_wr` for LBAs 65..77, then `sd_rd` for LBAs 78..90.
- Drives 0 and 1 pending in the same cycle → drive 0 is serviced first, then drive 1. `buf_drive` switches 0→1.
- Dirty track, then `img_mounted[0]` → no write-back; reload from LBA `13*track`.
- `reset_n` low during sector 7 of a load → requests low immediately. After release, a full reload from sector 0.
